// File: rtl/cmp_shared_dmem.sv
// Shared data memory for the CMP: NUM_PORTS cores reach one DEPTH x DATA_WIDTH array through a
// round-robin arbiter, one access per clock, with registered read data and per-port stall counters.
module cmp_shared_dmem #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [0:NUM_PORTS-1]             req_en,
  input  logic [0:NUM_PORTS-1]             req_wr_en,
  input  logic [0:NUM_PORTS*ADDR_WIDTH-1]  req_addr,
  input  logic [0:NUM_PORTS*DATA_WIDTH-1]  req_wdata,
  output logic [0:NUM_PORTS-1]             gnt,
  output logic [0:NUM_PORTS-1]             rvalid,
  output logic [0:DATA_WIDTH-1]            rdata,
  output logic [0:NUM_PORTS*CNT_WIDTH-1]   stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [0:DATA_WIDTH-1] MEM [0:DEPTH-1];

  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         next_ptr;
  logic [PW-1:0]         win_idx;
  logic                  win_vld;
  logic                  grant_any;
  logic                  win_wr;
  logic [0:ADDR_WIDTH-1] win_addr;
  logic [0:DATA_WIDTH-1] win_wdata;
  logic [AW-1:0]         mem_index;
  logic                  unused_addr_hi;

  // Scan from the farthest candidate back to rr_ptr so the closest requester is assigned last.
  always_comb begin
    int cand;
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (req_en[cand]) begin
        win_vld = 1'b1;
        win_idx = PW'(cand);
      end
    end
  end

  assign grant_any = win_vld && !reset;

  always_comb begin
    gnt = '0;
    if (grant_any) gnt[win_idx] = 1'b1;
  end

  always_comb begin
    win_wr    = req_wr_en[win_idx];
    win_addr  = req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    win_wdata = req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Only the low AW address bits select a word; higher bits alias modulo DEPTH.
  assign mem_index      = win_addr[ADDR_WIDTH-AW +: AW];
  assign unused_addr_hi = ^win_addr[0:ADDR_WIDTH-AW-1];

  assign next_ptr = (win_idx == PW'(NUM_PORTS - 1)) ? '0 : win_idx + PW'(1);

  always_ff @(posedge clk) begin
    if (grant_any && win_wr) MEM[mem_index] <= win_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= '0;
      if (grant_any) begin
        rr_ptr <= next_ptr;
        if (!win_wr) begin
          rvalid <= gnt;
          rdata  <= MEM[mem_index];
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_stall
    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt <= '0;
      end else if (req_en[p] && !gnt[p] && (cnt != {CNT_WIDTH{1'b1}})) begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end

    assign stall_cnt[p*CNT_WIDTH +: CNT_WIDTH] = cnt;
  end

endmodule
